// File: rtl/job_scheduler.sv
// Splits a mining job's nonce range across NUM_CORES cores, starts them together, and
// funnels their golden nonces through a round-robin arbiter into a small FIFO.
module job_scheduler #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    hash_clk,
    input  logic                    reset_n,
    input  logic                    new_work,
    input  logic [31:0]             nonce_min,
    input  logic [31:0]             nonce_max,
    output logic [NUM_CORES-1:0]    core_start,
    output logic                    core_abort,
    output logic [32*NUM_CORES-1:0] core_min,
    output logic [32*NUM_CORES-1:0] core_max,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES-1:0]    core_gvalid,
    input  logic [32*NUM_CORES-1:0] core_gnonce,
    output logic [NUM_CORES-1:0]    core_gack,
    output logic                    golden_valid,
    output logic [31:0]             golden_nonce,
    input  logic                    golden_ready,
    output logic                    busy,
    output logic                    job_done,
    output logic                    job_error
);
    localparam int unsigned CoreW = $clog2(NUM_CORES);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam logic [CoreW-1:0] LastCore = CoreW'(NUM_CORES - 1);
    localparam logic [PtrW:0]    FullCnt  = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StSplit, StStart, StRun, StDone} state_e;

    state_e r_state, w_state_next;

    logic [31:0]          r_max, r_slice, r_acc;
    logic [CoreW-1:0]     r_idx, r_rr_ptr;
    logic [31:0]          r_cmin [NUM_CORES];
    logic [31:0]          r_cmax [NUM_CORES];
    logic [NUM_CORES-1:0] r_done_mask;
    logic                 r_abort, r_job_error, r_job_done;
    logic [31:0]          r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [PtrW:0]        r_count;

    logic [32:0]          w_span;
    logic                 w_invalid, w_active, w_abort, w_load;
    logic [NUM_CORES-1:0] w_started, w_mask_next, w_gack;
    logic [31:0]          w_acc_next, w_split_max, w_gnonce;
    logic [CoreW-1:0]     w_grant_idx;
    logic                 w_found, w_pop, w_push, w_arb_en;

    assign w_span    = {1'b0, nonce_max} - {1'b0, nonce_min} + 33'd1;
    assign w_invalid = nonce_max < nonce_min;
    assign w_active  = (r_state == StSplit) || (r_state == StStart) || (r_state == StRun);
    assign w_abort   = new_work && w_active;
    assign w_load    = new_work && !w_invalid;

    // With a zero slice only the last core gets real work.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_started[i] = (r_slice != 32'd0) || (i == NUM_CORES - 1);
        end
    end

    assign w_mask_next = r_done_mask | (core_done & w_started);
    assign w_acc_next  = r_acc + r_slice;
    assign w_split_max = (r_idx == LastCore)   ? r_max :
                         (r_slice == 32'd0)    ? r_acc : w_acc_next - 32'd1;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StSplit: if (r_idx == LastCore) w_state_next = StStart;
            StStart: w_state_next = StRun;
            StRun:   if (&w_mask_next) w_state_next = StDone;
            default: ;
        endcase
        if (new_work) begin
            if (!w_invalid)    w_state_next = StSplit;
            else if (w_active) w_state_next = StIdle;
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_max       <= '0;
            r_slice     <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_done_mask <= '0;
            r_abort     <= 1'b0;
            r_job_error <= 1'b0;
            r_job_done  <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_cmin[i] <= '0;
                r_cmax[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_abort     <= w_abort;
            r_job_error <= new_work && w_invalid;
            r_job_done  <= (r_state == StRun) && (&w_mask_next) && !new_work;
            if (w_load) begin
                r_max   <= nonce_max;
                r_slice <= 32'(w_span >> CoreW);
                r_acc   <= nonce_min;
                r_idx   <= '0;
            end else if (r_state == StSplit) begin
                r_cmin[r_idx] <= r_acc;
                r_cmax[r_idx] <= w_split_max;
                r_acc         <= w_acc_next;
                r_idx         <= r_idx + 1'b1;
            end
            // Cores that were never started are pre-marked as done.
            if (new_work)                r_done_mask <= '0;
            else if (r_state == StStart) r_done_mask <= ~w_started;
            else if (r_state == StRun)   r_done_mask <= w_mask_next;
        end
    end

    always_comb begin
        logic [CoreW-1:0] cand;
        w_found     = 1'b0;
        w_grant_idx = r_rr_ptr;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = r_rr_ptr + CoreW'(k);
            if (!w_found && core_gvalid[cand]) begin
                w_found     = 1'b1;
                w_grant_idx = cand;
            end
        end
        w_gnonce = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_grant_idx == CoreW'(i)) w_gnonce = core_gnonce[i*32 +: 32];
        end
    end

    assign w_pop    = golden_valid && golden_ready;
    assign w_arb_en = ((r_state == StRun) || (r_state == StDone)) && !w_abort;
    assign w_push   = w_arb_en && w_found && ((r_count != FullCnt) || w_pop);

    always_comb begin
        w_gack = '0;
        if (w_push) w_gack[w_grant_idx] = 1'b1;
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_gnonce;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_rr_ptr        <= w_grant_idx + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_pack
        assign core_min[32*g +: 32] = r_cmin[g];
        assign core_max[32*g +: 32] = r_cmax[g];
    end

    assign core_start   = (r_state == StStart) ? w_started : '0;
    assign core_abort   = r_abort;
    assign core_gack    = w_gack;
    assign golden_valid = (r_count != '0);
    assign golden_nonce = r_mem[r_rd_ptr];
    assign busy         = w_active;
    assign job_done     = r_job_done;
    assign job_error    = r_job_error;

endmodule

// File: tb/tb_job_scheduler.sv
// Directed bench for job_scheduler: one instance with an 8-deep FIFO, one with a 2-deep FIFO.
module tb_job_scheduler;
    logic         hash_clk;
    logic         reset_n;

    logic         new_work, golden_ready;
    logic [31:0]  nonce_min, nonce_max;
    logic [3:0]   core_done, core_gvalid;
    logic [127:0] core_gnonce;
    logic [3:0]   core_start, core_gack;
    logic [127:0] core_min, core_max;
    logic         core_abort, golden_valid, busy, job_done, job_error;
    logic [31:0]  golden_nonce;

    logic         b_new_work, b_golden_ready;
    logic [31:0]  b_nonce_min, b_nonce_max;
    logic [3:0]   b_core_done, b_core_gvalid;
    logic [127:0] b_core_gnonce;
    logic [3:0]   b_core_start, b_core_gack;
    logic [127:0] b_core_min, b_core_max;
    logic         b_core_abort, b_golden_valid, b_busy, b_job_done, b_job_error;
    logic [31:0]  b_golden_nonce;

    int n_checks = 0;
    int n_errors = 0;

    job_scheduler #(.NUM_CORES(4), .FIFO_DEPTH(8)) dut (
        .hash_clk(hash_clk), .reset_n(reset_n), .new_work(new_work),
        .nonce_min(nonce_min), .nonce_max(nonce_max), .core_start(core_start),
        .core_abort(core_abort), .core_min(core_min), .core_max(core_max),
        .core_done(core_done), .core_gvalid(core_gvalid), .core_gnonce(core_gnonce),
        .core_gack(core_gack), .golden_valid(golden_valid), .golden_nonce(golden_nonce),
        .golden_ready(golden_ready), .busy(busy), .job_done(job_done), .job_error(job_error)
    );

    job_scheduler #(.NUM_CORES(4), .FIFO_DEPTH(2)) dut_b (
        .hash_clk(hash_clk), .reset_n(reset_n), .new_work(b_new_work),
        .nonce_min(b_nonce_min), .nonce_max(b_nonce_max), .core_start(b_core_start),
        .core_abort(b_core_abort), .core_min(b_core_min), .core_max(b_core_max),
        .core_done(b_core_done), .core_gvalid(b_core_gvalid), .core_gnonce(b_core_gnonce),
        .core_gack(b_core_gack), .golden_valid(b_golden_valid),
        .golden_nonce(b_golden_nonce), .golden_ready(b_golden_ready), .busy(b_busy),
        .job_done(b_job_done), .job_error(b_job_error)
    );

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] mn, input logic [31:0] mx);
        nonce_min = mn;
        nonce_max = mx;
        new_work  = 1'b1;
        tick();
        new_work  = 1'b0;
    endtask

    localparam logic [127:0] FullMin  = 128'hC0000000_80000000_40000000_00000000;
    localparam logic [127:0] FullMax  = 128'hFFFFFFFF_BFFFFFFF_7FFFFFFF_3FFFFFFF;
    localparam logic [127:0] SmallMin = 128'h00000010_0000000E_0000000C_0000000A;
    localparam logic [127:0] SmallMax = 128'h00000014_0000000F_0000000D_0000000B;
    localparam logic [127:0] FiveAll  = 128'h00000005_00000005_00000005_00000005;

    initial begin
        reset_n = 1'b0;
        new_work = 1'b0; golden_ready = 1'b0; nonce_min = '0; nonce_max = '0;
        core_done = '0; core_gvalid = '0; core_gnonce = '0;
        b_new_work = 1'b0; b_golden_ready = 1'b0; b_nonce_min = '0; b_nonce_max = '0;
        b_core_done = '0; b_core_gvalid = '0; b_core_gnonce = '0;
        tick();
        tick();
        check("rst_start", core_start, 4'h0);
        check("rst_abort", core_abort, 1'b0);
        check("rst_min", core_min, 128'h0);
        check("rst_max", core_max, 128'h0);
        check("rst_gvalid", golden_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", job_done, 1'b0);
        check("rst_error", job_error, 1'b0);
        reset_n = 1'b1;
        tick();

        // Full 32-bit range: start at cycle 5.
        launch(32'h0, 32'hFFFFFFFF);
        check("full_busy", busy, 1'b1);
        check("full_nostart1", core_start, 4'h0);
        repeat (3) tick();
        check("full_nostart4", core_start, 4'h0);
        tick();
        check("full_start", core_start, 4'hF);
        check("full_min", core_min, FullMin);
        check("full_max", core_max, FullMax);
        tick();
        check("full_start_pulse", core_start, 4'h0);
        core_done = 4'hF;
        tick();
        check("full_job_done", job_done, 1'b1);
        check("full_idle_busy", busy, 1'b0);
        core_done = 4'h0;
        tick();
        check("full_job_done_end", job_done, 1'b0);

        // Span of 11: last core absorbs the remainder; done bits in order 2, 0, 3, 1.
        launch(32'd10, 32'd20);
        repeat (4) tick();
        check("small_start", core_start, 4'hF);
        check("small_min", core_min, SmallMin);
        check("small_max", core_max, SmallMax);
        tick();
        core_done = 4'b0100; tick(); check("small_d2", job_done, 1'b0);
        core_done = 4'b0101; tick(); check("small_d0", job_done, 1'b0);
        core_done = 4'b1101; tick(); check("small_d3", job_done, 1'b0);
        core_done = 4'b1111; tick(); check("small_d1", job_done, 1'b1);
        tick();
        check("small_once", job_done, 1'b0);
        core_done = 4'h0;

        // Single-nonce job: only the last core runs.
        launch(32'd5, 32'd5);
        repeat (4) tick();
        check("one_start", core_start, 4'b1000);
        check("one_min", core_min, FiveAll);
        check("one_max", core_max, FiveAll);
        tick();
        check("one_busy", busy, 1'b1);
        core_done = 4'b1000;
        tick();
        check("one_job_done", job_done, 1'b1);
        core_done = 4'h0;

        // Rejected job from DONE.
        launch(32'h100, 32'hFF);
        check("err_pulse", job_error, 1'b1);
        check("err_busy", busy, 1'b0);
        check("err_nostart", core_start, 4'h0);
        tick();
        check("err_pulse_end", job_error, 1'b0);
        repeat (4) tick();
        check("err_still_nostart", core_start, 4'h0);
        check("err_still_idle", busy, 1'b0);

        // Queue three nonces, then abort with a new job coinciding with the final done.
        launch(32'h0, 32'hFFFFFFFF);
        repeat (5) tick();
        core_gnonce = 128'h00000000_00000033_00000022_00000011;
        core_gvalid = 4'b0111;
        #1 check("ab_gack0", core_gack, 4'b0001);
        tick();
        check("ab_head", golden_nonce, 32'h11);
        core_gvalid = 4'b0110;
        #1 check("ab_gack1", core_gack, 4'b0010);
        tick();
        core_gvalid = 4'b0100;
        #1 check("ab_gack2", core_gack, 4'b0100);
        tick();
        core_gvalid = 4'b0000;
        #1 check("ab_gack_none", core_gack, 4'b0000);
        check("ab_queued", golden_valid, 1'b1);
        nonce_min = 32'd10;
        nonce_max = 32'd20;
        core_done = 4'hF;
        new_work  = 1'b1;
        tick();
        new_work  = 1'b0;
        core_done = 4'h0;
        check("ab_abort", core_abort, 1'b1);
        check("ab_flushed", golden_valid, 1'b0);
        check("ab_no_done", job_done, 1'b0);
        check("ab_busy", busy, 1'b1);
        tick();
        check("ab_abort_end", core_abort, 1'b0);
        check("ab_no_done2", job_done, 1'b0);
        repeat (3) tick();
        check("ab_restart", core_start, 4'hF);
        check("ab_min", core_min, SmallMin);
        check("ab_max", core_max, SmallMax);
        tick();
        core_done = 4'hF;
        tick();
        check("ab_new_done", job_done, 1'b1);
        core_done = 4'h0;

        // Two-deep FIFO: backpressure holds cores, round-robin order preserved.
        b_nonce_min = 32'h0;
        b_nonce_max = 32'hFFFFFFFF;
        b_new_work  = 1'b1;
        tick();
        b_new_work  = 1'b0;
        repeat (5) tick();
        b_core_gnonce = 128'h000000A3_000000A2_000000A1_000000A0;
        b_core_gvalid = 4'b1111;
        #1 check("bp_gack0", b_core_gack, 4'b0001);
        tick();
        b_core_gvalid = 4'b1110;
        #1 check("bp_gack1", b_core_gack, 4'b0010);
        check("bp_head0", b_golden_nonce, 32'hA0);
        tick();
        b_core_gvalid = 4'b1100;
        #1 check("bp_full_hold", b_core_gack, 4'b0000);
        tick();
        check("bp_full_hold2", b_core_gack, 4'b0000);
        b_golden_ready = 1'b1;
        #1 check("bp_gack2", b_core_gack, 4'b0100);
        check("bp_pop_a0", b_golden_nonce, 32'hA0);
        tick();
        b_core_gvalid = 4'b1000;
        #1 check("bp_gack3", b_core_gack, 4'b1000);
        check("bp_pop_a1", b_golden_nonce, 32'hA1);
        tick();
        b_core_gvalid = 4'b0000;
        #1 check("bp_pop_a2", b_golden_nonce, 32'hA2);
        check("bp_gack_none", b_core_gack, 4'b0000);
        check("bp_valid_a2", b_golden_valid, 1'b1);
        tick();
        check("bp_pop_a3", b_golden_nonce, 32'hA3);
        check("bp_valid_a3", b_golden_valid, 1'b1);
        tick();
        check("bp_empty", b_golden_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
